// File: rtl/perceptron_pkg.sv
// perceptron_pkg: shared sizes, weight/entry types and packing helpers for the perceptron trainer.
// Contents: GHR_SIZE, WEIGHT_W, HOB_W, LOB_W, INDEX_W, THETA; weight_t, entry_t;
//           neg_sat (saturating negation), pack_data (HOB/LOB table image), pack_hob_c (HOB of negated weights).
package perceptron_pkg;
    localparam int GHR_SIZE = 12;
    localparam int WEIGHT_W = 8;
    localparam int HOB_W    = 4;
    localparam int LOB_W    = WEIGHT_W - HOB_W;
    localparam int INDEX_W  = 6;
    localparam int THETA    = 37;
    localparam int ENTRIES  = 1 << INDEX_W;

    typedef logic signed [WEIGHT_W-1:0] weight_t;
    typedef weight_t [GHR_SIZE-1:0] entry_t;

    localparam weight_t W_MAX = {1'b0, {(WEIGHT_W-1){1'b1}}};
    localparam weight_t W_MIN = {1'b1, {(WEIGHT_W-1){1'b0}}};

    // -W_MIN is not representable, so it clamps to W_MAX
    function automatic weight_t neg_sat(input weight_t w);
        return (w == W_MIN) ? W_MAX : weight_t'(-w);
    endfunction

    // {HOB nibbles, LOB nibbles}; weight i sits at nibble i of each half
    function automatic logic [GHR_SIZE*WEIGHT_W-1:0] pack_data(input entry_t e);
        logic [GHR_SIZE*WEIGHT_W-1:0] d = '0;
        for (int i = 0; i < GHR_SIZE; i++) begin
            d[GHR_SIZE*LOB_W + i*HOB_W +: HOB_W] = e[i][WEIGHT_W-1 -: HOB_W];
            d[i*LOB_W +: LOB_W]                  = e[i][LOB_W-1:0];
        end
        return d;
    endfunction

    function automatic logic [GHR_SIZE*HOB_W-1:0] pack_hob_c(input entry_t e);
        logic [GHR_SIZE*HOB_W-1:0] d = '0;
        weight_t n;
        for (int i = 0; i < GHR_SIZE; i++) begin
            n = neg_sat(e[i]);
            d[i*HOB_W +: HOB_W] = n[WEIGHT_W-1 -: HOB_W];
        end
        return d;
    endfunction
endpackage

// File: rtl/weight_sat_step.sv
// weight_sat_step: one saturating +1/-1 step of a signed perceptron weight.
// Ports: w_i current weight, inc_i 1=increment 0=decrement, w_o stepped weight, sat_o step was clamped.
module weight_sat_step
    import perceptron_pkg::*;
(
    input  weight_t w_i,
    input  logic    inc_i,
    output weight_t w_o,
    output logic    sat_o
);
    always_comb begin
        sat_o = inc_i ? (w_i == W_MAX) : (w_i == W_MIN);
        w_o   = sat_o ? w_i : (inc_i ? w_i + weight_t'(1) : w_i - weight_t'(1));
    end
endmodule

// File: rtl/perceptron_trainer.sv
// perceptron_trainer: trains perceptron weights from resolved branches and emits packed table writes.
// Ports: clk/reset (sync, active-high); stall freezes pipeline and masks up_wen;
//        upd_valid/upd_ready handshake with upd_pc, upd_dir, upd_pred_dir, upd_sum, upd_ghr;
//        up_wen/up_addr/up_data/up_hob_c table write port; busy = clear sweep running;
//        debug_sel/debug_out statistics readback.
// Optional: define PERCEPTRON_TRAINER_STATS_EN for accepted/train/mispredict/saturation counters.
module perceptron_trainer
    import perceptron_pkg::*;
(
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         stall,
    input  logic                         upd_valid,
    output logic                         upd_ready,
    input  logic [31:0]                  upd_pc,
    input  logic                         upd_dir,
    input  logic                         upd_pred_dir,
    input  logic [9:0]                   upd_sum,
    input  logic [GHR_SIZE-1:0]          upd_ghr,
    output logic                         up_wen,
    output logic [INDEX_W-1:0]           up_addr,
    output logic [GHR_SIZE*WEIGHT_W-1:0] up_data,
    output logic [GHR_SIZE*HOB_W-1:0]    up_hob_c,
    output logic                         busy,
    input  logic [1:0]                   debug_sel,
    output logic [31:0]                  debug_out
);
    entry_t mem [ENTRIES];
    logic [INDEX_W-1:0] sweep_q, s1_idx_q, s2_idx_q, rd_idx;
    logic busy_q, s1_valid_q, s2_valid_q, s1_dir_q, s1_pred_q, s2_train_q;
    logic [9:0] s1_sum_q, sum_abs;
    logic [GHR_SIZE-1:0] s1_ghr_q, s2_sat_q, sat_d;
    entry_t s1_rd_q, s2_w_q, rd_d, cur, s2_w_d;
    weight_t step_w [GHR_SIZE];
    logic step_sat [GHR_SIZE];
    logic accept, upd_wr, sweep_wr, train_d, out_v, unused_ok;

    assign busy      = reset | busy_q;
    assign upd_ready = ~busy & ~stall;
    assign accept    = upd_valid & upd_ready;
    assign upd_wr    = ~reset & ~stall & s2_valid_q & s2_train_q;
    assign sweep_wr  = ~reset & ~stall & busy_q;
    assign rd_idx    = upd_pc[INDEX_W+1:2];
    // write-first read so an update leaving S2 this edge is seen by the one entering
    assign rd_d      = (upd_wr && s2_idx_q == rd_idx) ? s2_w_q : mem[rd_idx];
    // S2 holds the freshest copy of its entry until it lands in the shadow RAM
    assign cur       = (s2_valid_q && s2_train_q && s2_idx_q == s1_idx_q) ? s2_w_q : s1_rd_q;
    assign sum_abs   = s1_sum_q[9] ? ((s1_sum_q == 10'h200) ? 10'd511 : 10'(-s1_sum_q)) : s1_sum_q;
    assign train_d   = (s1_dir_q != s1_pred_q) | (sum_abs <= 10'(THETA));

    for (genvar g = 0; g < GHR_SIZE; g++) begin : g_step
        weight_sat_step u_step (
            .w_i   (cur[g]),
            .inc_i (~(s1_dir_q ^ s1_ghr_q[g])),
            .w_o   (step_w[g]),
            .sat_o (step_sat[g])
        );
    end

    always_comb begin
        s2_w_d = cur;
        sat_d  = '0;
        for (int i = 0; i < GHR_SIZE; i++) begin
            s2_w_d[i] = train_d ? step_w[i] : cur[i];
            sat_d[i]  = train_d & step_sat[i];
        end
    end

    always_ff @(posedge clk) begin
        if (sweep_wr) mem[sweep_q] <= '0;
        else if (upd_wr) mem[s2_idx_q] <= s2_w_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sweep_q    <= '0;
            busy_q     <= 1'b1;
            s1_valid_q <= 1'b0;
            s2_valid_q <= 1'b0;
        end else if (!stall) begin
            if (busy_q) begin
                sweep_q <= sweep_q + 1'b1;
                busy_q  <= (sweep_q != '1);
            end
            s1_valid_q <= accept;
            s2_valid_q <= s1_valid_q;
        end
    end

    always_ff @(posedge clk) begin
        if (!stall) begin
            if (accept) begin
                s1_idx_q  <= rd_idx;
                s1_dir_q  <= upd_dir;
                s1_pred_q <= upd_pred_dir;
                s1_sum_q  <= upd_sum;
                s1_ghr_q  <= upd_ghr;
                s1_rd_q   <= rd_d;
            end
            s2_idx_q   <= s1_idx_q;
            s2_train_q <= train_d;
            s2_w_q     <= s2_w_d;
            s2_sat_q   <= sat_d;
        end
    end

    assign out_v    = ~reset & ~busy_q & s2_valid_q;
    assign up_wen   = sweep_wr | upd_wr;
    assign up_addr  = out_v ? s2_idx_q : ((~reset & busy_q) ? sweep_q : '0);
    assign up_data  = out_v ? pack_data(s2_w_q) : '0;
    assign up_hob_c = out_v ? pack_hob_c(s2_w_q) : '0;
    assign unused_ok = ^{upd_pc[31:INDEX_W+2], upd_pc[1:0], debug_sel, s2_sat_q};

`ifdef PERCEPTRON_TRAINER_STATS_EN
    logic [31:0] cnt_q [4];
    always_ff @(posedge clk) begin
        if (reset) cnt_q <= '{default: '0};
        else begin
            cnt_q[0] <= cnt_q[0] + 32'(accept);
            cnt_q[1] <= cnt_q[1] + 32'(upd_wr);
            cnt_q[2] <= cnt_q[2] + 32'(accept & (upd_dir != upd_pred_dir));
            cnt_q[3] <= cnt_q[3] + (upd_wr ? 32'($countones(s2_sat_q)) : 32'd0);
        end
    end
    assign debug_out = reset ? '0 : cnt_q[debug_sel];
`else
    assign debug_out = '0;
`endif
endmodule

// File: tb/tb_perceptron_trainer.sv
// tb_perceptron_trainer: directed self-checking bench for perceptron_trainer.
module tb_perceptron_trainer;
    logic clk = 1'b0, reset = 1'b1, stall = 1'b0, upd_valid = 1'b0, upd_dir = 1'b0, upd_pred_dir = 1'b0;
    logic upd_ready, up_wen, busy;
    logic [31:0] upd_pc = '0, debug_out;
    logic [9:0] upd_sum = '0;
    logic [11:0] upd_ghr = '0;
    logic [5:0] up_addr;
    logic [95:0] up_data;
    logic [47:0] up_hob_c;
    logic [1:0] debug_sel = '0;
    int n_assert = 0, n_fail = 0;

    always #5 clk = ~clk;

    perceptron_trainer dut (
        .clk(clk), .reset(reset), .stall(stall), .upd_valid(upd_valid), .upd_ready(upd_ready),
        .upd_pc(upd_pc), .upd_dir(upd_dir), .upd_pred_dir(upd_pred_dir), .upd_sum(upd_sum),
        .upd_ghr(upd_ghr), .up_wen(up_wen), .up_addr(up_addr), .up_data(up_data),
        .up_hob_c(up_hob_c), .busy(busy), .debug_sel(debug_sel), .debug_out(debug_out)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [159:0] obs, input logic [159:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wr(input string tag, input logic wen, input logic [5:0] addr,
                      input logic [95:0] data, input logic [47:0] hobc);
        check({tag, "_wen"}, up_wen, wen);
        check({tag, "_addr"}, up_addr, addr);
        check({tag, "_data"}, up_data, data);
        check({tag, "_hobc"}, up_hob_c, hobc);
    endtask

    task automatic stat(input string tag, input logic [1:0] sel, input logic [31:0] exp);
        debug_sel = sel;
        #1;
        check(tag, debug_out, exp);
    endtask

    task automatic sweep(input string tag);
        for (int k = 0; k < 64; k++) begin
            check(tag, {up_wen, busy, up_addr, up_data, up_hob_c}, {1'b1, 1'b1, 6'(k), 96'h0, 48'h0});
            tick();
        end
        check({tag, "_busy"}, busy, 1'b0);
        check({tag, "_ready"}, upd_ready, 1'b1);
        check({tag, "_wen"}, up_wen, 1'b0);
    endtask

    task automatic send(input logic [31:0] pc, input logic dir, input logic pred,
                        input logic [9:0] sum, input logic [11:0] ghr);
        upd_valid = 1'b1; upd_pc = pc; upd_dir = dir; upd_pred_dir = pred; upd_sum = sum; upd_ghr = ghr;
        tick();
        upd_valid = 1'b0;
    endtask

    initial begin
        tick(); tick();
        check("rst_busy", busy, 1'b1);
        check("rst_wen", up_wen, 1'b0);
        check("rst_ready", upd_ready, 1'b0);
        check("rst_addr", up_addr, 6'd0);
        check("rst_dbg", debug_out, 32'd0);
        reset = 1'b0;
        #1;
        sweep("sweep0");

        send(32'h10, 1'b1, 1'b0, 10'd0, 12'hFFF);
        tick();
        wr("t1", 1'b1, 6'd4, {48'h0, {12{4'h1}}}, {12{4'hF}});
        tick();
        check("t1_once", up_wen, 1'b0);

        send(32'h10, 1'b1, 1'b1, 10'd100, 12'hFFF);
        tick();
        check("t2_nowr", up_wen, 1'b0);
`ifdef PERCEPTRON_TRAINER_STATS_EN
        stat("t2_acc", 2'd0, 32'd2);
        stat("t2_trn", 2'd1, 32'd1);
        stat("t2_mis", 2'd2, 32'd1);
`else
        stat("t2_dbg0", 2'd0, 32'd0);
        stat("t2_dbg3", 2'd3, 32'd0);
`endif

        upd_valid = 1'b1; upd_pc = 32'h20; upd_dir = 1'b0; upd_pred_dir = 1'b0; upd_sum = 10'd0; upd_ghr = 12'hFFF;
        tick(); tick();
        upd_valid = 1'b0;
        wr("b2b1", 1'b1, 6'd8, {96{1'b1}}, 48'h0);
        tick();
        wr("b2b2", 1'b1, 6'd8, {{12{4'hF}}, {12{4'hE}}}, 48'h0);

        send(32'h30, 1'b1, 1'b0, 10'd50, 12'h0F0);
        tick();
        wr("mix", 1'b1, 6'd12, {48'hFFFF0000FFFF, 48'hFFFF1111FFFF}, 48'h0000FFFF0000);

        send(32'h40, 1'b1, 1'b1, 10'd37, 12'hFFF);
        tick();
        wr("th37", 1'b1, 6'd16, {48'h0, {12{4'h1}}}, {12{4'hF}});
        send(32'h40, 1'b1, 1'b1, 10'd38, 12'hFFF);
        tick();
        check("th38", up_wen, 1'b0);
        send(32'h40, 1'b1, 1'b1, 10'h3DB, 12'hFFF);
        tick();
        wr("thm37", 1'b1, 6'd16, {48'h0, {12{4'h2}}}, {12{4'hF}});
        send(32'h40, 1'b1, 1'b1, 10'h200, 12'hFFF);
        tick();
        check("thm512", up_wen, 1'b0);
        send(32'h40, 1'b1, 1'b1, 10'h3DA, 12'hFFF);
        tick();
        check("thm38", up_wen, 1'b0);

        upd_valid = 1'b1; upd_pc = 32'h80; upd_dir = 1'b1; upd_pred_dir = 1'b1; upd_sum = 10'd0; upd_ghr = 12'hFFF;
        repeat (200) tick();
        upd_valid = 1'b0;
        tick();
        wr("sat", 1'b1, 6'd32, {{12{4'h7}}, {12{4'hF}}}, {12{4'h8}});
        tick();
`ifdef PERCEPTRON_TRAINER_STATS_EN
        stat("sat_acc", 2'd0, 32'd210);
        stat("sat_trn", 2'd1, 32'd206);
        stat("sat_mis", 2'd2, 32'd2);
        stat("sat_cnt", 2'd3, 32'd876);
`else
        stat("sat_dbg", 2'd3, 32'd0);
`endif

        send(32'h44, 1'b1, 1'b0, 10'd0, 12'hFFF);
        tick();
        stall = 1'b1;
        #1;
        wr("stl_hold", 1'b0, 6'd17, {48'h0, {12{4'h1}}}, {12{4'hF}});
        check("stl_ready", upd_ready, 1'b0);
        tick();
        wr("stl_hold2", 1'b0, 6'd17, {48'h0, {12{4'h1}}}, {12{4'hF}});
        stall = 1'b0;
        #1;
        wr("stl_rel", 1'b1, 6'd17, {48'h0, {12{4'h1}}}, {12{4'hF}});
        tick();
        check("stl_once", up_wen, 1'b0);

        send(32'h48, 1'b1, 1'b0, 10'd0, 12'hFFF);
        reset = 1'b1;
        #1;
        check("rs_wen", up_wen, 1'b0);
        check("rs_busy", busy, 1'b1);
        tick();
        check("rs_wen2", up_wen, 1'b0);
        check("rs_addr", up_addr, 6'd0);
        check("rs_dbg", debug_out, 32'd0);
        reset = 1'b0;
        #1;
        sweep("sweep1");

        send(32'h10, 1'b1, 1'b0, 10'd0, 12'hFFF);
        tick();
        wr("clr", 1'b1, 6'd4, {48'h0, {12{4'h1}}}, {12{4'hF}});
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
